// File: rtl/debounce_pkg.sv
// Shared helpers for the multi-channel debouncer: width calculation, derived
// constants and the parameter sanity predicate used at elaboration.
package debounce_pkg;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int width_for(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   function automatic int calc_div(input int clk_hz, input int sample_hz);
      return clk_hz / sample_hz;
   endfunction

   function automatic int calc_cnt_w(input int stable_cnt);
      return width_for(stable_cnt);
   endfunction

   function automatic int calc_long_w(input int long_ticks);
      return width_for(long_ticks + 1);
   endfunction

   function automatic bit params_ok(input int div, input int stable_cnt,
                                    input int sync_stages);
      return (div >= 2) && (stable_cnt >= 1) && (sync_stages >= 2);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: synchroniser, stability counter, level and edge pulses.
// The hold counter and long_o exist only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_CNT  = 20,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 0
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,parameter int LONG_TICKS = 2000
`endif
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic pb_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,output logic long_o
`endif
);

   localparam int               CNT_W    = calc_cnt_w(STABLE_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   raw;
   logic                   s;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // Inversion happens before the synchroniser so "pressed" is always 1 inside.
   assign raw = (ACTIVE_LOW != 0) ? ~pb_i : pb_i;
   assign s   = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick_i) begin
         if (s == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int                LONG_W   = calc_long_w(LONG_TICKS);
   localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);

   logic [LONG_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;

   // Saturating at LONG_MAX limits the long pulse to one per press.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!level_q) begin
         hold_d = '0;
      end else if (tick_i && (hold_q != LONG_MAX)) begin
         hold_d = hold_q + LONG_W'(1);
         long_d = (hold_d == LONG_MAX);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_o = long_q;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner sharing one sample tick across channels.
// Optional long-press detection (pb_long_o) is enabled by DEBOUNCE_LONG_PRESS_EN.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CLK_HZ      = 50000000,
   parameter int SAMPLE_HZ   = 1000,
   parameter int STABLE_CNT  = 20,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 0,
   parameter int LONG_TICKS  = 2000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_CH-1:0] pb_in_i,
   output logic [N_CH-1:0] pb_level_o,
   output logic [N_CH-1:0] pb_rise_o,
   output logic [N_CH-1:0] pb_fall_o,
   output logic            sample_tick_o
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,output logic [N_CH-1:0] pb_long_o
`endif
);

   localparam int                DIV       = calc_div(CLK_HZ, SAMPLE_HZ);
   localparam int                TICK_W    = width_for(DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);

   if (!params_ok(DIV, STABLE_CNT, SYNC_STAGES) || (LONG_TICKS < 1)) begin : g_param_check
      $error("debounce_multi: need DIV>=2, STABLE_CNT>=1, SYNC_STAGES>=2, LONG_TICKS>=1");
   end

   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick_q, tick_d;

   // The tick is registered from the next count so it is high while the count is DIV-1.
   always_comb begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
      tick_d     = (tick_cnt_d == TICK_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
      end
   end

   assign sample_tick_o = tick_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_chan #(
         .STABLE_CNT  (STABLE_CNT),
         .SYNC_STAGES (SYNC_STAGES),
         .ACTIVE_LOW  (ACTIVE_LOW)
`ifdef DEBOUNCE_LONG_PRESS_EN
         ,.LONG_TICKS (LONG_TICKS)
`endif
      ) u_chan (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .tick_i  (tick_q),
         .pb_i    (pb_in_i[i]),
         .level_o (pb_level_o[i]),
         .rise_o  (pb_rise_o[i]),
         .fall_o  (pb_fall_o[i])
`ifdef DEBOUNCE_LONG_PRESS_EN
         ,.long_o (pb_long_o[i])
`endif
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues expected pulses and level
// probes by cycle; a negedge monitor compares whatever the DUT presents.
module tb_debounce_multi;

   localparam int N_CH       = 4;
   localparam int CLK_HZ     = 1000;
   localparam int SAMPLE_HZ  = 100;
   localparam int DIV        = CLK_HZ / SAMPLE_HZ;
   localparam int STABLE_CNT = 4;
   localparam int LONG_TICKS = 8;

   localparam int K_LEVEL = 0;
   localparam int K_TICK  = 1;
   localparam int K_QUIET = 2;

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] lng;
   } pulse_t;

   typedef struct {
      int         cyc;
      int         kind;
      logic [3:0] val;
   } probe_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] pb  = 4'hF;
   logic [3:0] level_w, rise_w, fall_w, lng_w;
   logic       tick_w;

   int     cyc   = 0;
   int     c0    = 0;
   int     n_vec = 0;
   int     n_bad = 0;
   pulse_t evq[$];
   probe_t prq[$];
   bit     ev_hit;
   logic [3:0] got;
   string  pname;

   debounce_multi #(
      .N_CH        (N_CH),
      .CLK_HZ      (CLK_HZ),
      .SAMPLE_HZ   (SAMPLE_HZ),
      .STABLE_CNT  (STABLE_CNT),
      .SYNC_STAGES (2),
      .ACTIVE_LOW  (0),
      .LONG_TICKS  (LONG_TICKS)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pb_in_i       (pb),
      .pb_level_o    (level_w),
      .pb_rise_o     (rise_w),
      .pb_fall_o     (fall_w),
      .sample_tick_o (tick_w)
`ifdef DEBOUNCE_LONG_PRESS_EN
      ,.pb_long_o    (lng_w)
`endif
   );

`ifndef DEBOUNCE_LONG_PRESS_EN
   assign lng_w = 4'h0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: level/tick probes due this cycle, then pulse events.
   always @(negedge clk) begin
      for (int i = prq.size() - 1; i >= 0; i--) begin
         if (prq[i].cyc <= cyc) begin
            case (prq[i].kind)
               K_LEVEL: begin got = level_w;             pname = "level"; end
               K_TICK:  begin got = {3'b000, tick_w};    pname = "tick";  end
               default: begin got = rise_w | fall_w | lng_w; pname = "quiet"; end
            endcase
            n_vec++;
            if ((prq[i].cyc != cyc) || (got !== prq[i].val)) begin
               n_bad++;
               $display("FAIL %s@%0d got %h want %h", pname, prq[i].cyc, got, prq[i].val);
            end
            prq.delete(i);
         end
      end
      ev_hit = 1'b0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
         if (evq[i].cyc == cyc) begin
            ev_hit = 1'b1;
            n_vec++;
            if ({rise_w, fall_w, lng_w} !== {evq[i].rise, evq[i].fall, evq[i].lng}) begin
               n_bad++;
               $display("FAIL pulse@%0d rise/fall/long got %h/%h/%h want %h/%h/%h", cyc,
                        rise_w, fall_w, lng_w, evq[i].rise, evq[i].fall, evq[i].lng);
            end
            evq.delete(i);
         end else if (evq[i].cyc < cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL pulse@%0d missing, want rise/fall/long %h/%h/%h", evq[i].cyc,
                     evq[i].rise, evq[i].fall, evq[i].lng);
            evq.delete(i);
         end
      end
      if (!ev_hit && ((rise_w | fall_w | lng_w) != 4'h0)) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_pulse@%0d rise/fall/long got %h/%h/%h want 0/0/0", cyc,
                  rise_w, fall_w, lng_w);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   // Cycle of the qualifying pulse for an input change driven during cycle e:
   // two sync edges, first tick evaluation at a multiple of DIV after reset
   // release, then STABLE_CNT-1 more ticks.
   function automatic int pulse_at(input int e);
      int k;
      k = e - c0 + 3;
      if (k < DIV) k = DIV;
      k = ((k + DIV - 1) / DIV) * DIV;
      return c0 + k + DIV * (STABLE_CNT - 1);
   endfunction

   task automatic want_pulse(input int c, input logic [3:0] r, input logic [3:0] f,
                             input logic [3:0] l);
      pulse_t ev;
      for (int i = 0; i < evq.size(); i++) begin
         if (evq[i].cyc == c) begin
            evq[i].rise = evq[i].rise | r;
            evq[i].fall = evq[i].fall | f;
            evq[i].lng  = evq[i].lng | l;
            return;
         end
      end
      ev.cyc  = c;
      ev.rise = r;
      ev.fall = f;
      ev.lng  = l;
      evq.push_back(ev);
   endtask

   task automatic probe(input int c, input int kind, input logic [3:0] v);
      probe_t p;
      p.cyc  = c;
      p.kind = kind;
      p.val  = v;
      prq.push_back(p);
   endtask

   task automatic want_long(input int rise_cyc, input logic [3:0] ch);
`ifdef DEBOUNCE_LONG_PRESS_EN
      want_pulse(rise_cyc + LONG_TICKS * DIV, 4'h0, 4'h0, ch);
`else
      if (ch == 4'hF) $display("note: long-press disabled");
`endif
   endtask

   initial begin
      int p, p2, p3, e0, k1;

      // Reset held with all buttons high.
      rst = 1'b1;
      pb  = 4'hF;
      repeat (25) step();
      probe(cyc, K_LEVEL, 4'h0);
      probe(cyc, K_TICK, 4'h0);
      probe(cyc, K_QUIET, 4'h0);
      pb  = 4'h0;
      rst = 1'b0;
      c0  = cyc;
      probe(c0 + 8, K_TICK, 4'h0);
      probe(c0 + 9, K_TICK, 4'h1);
      probe(c0 + 10, K_TICK, 4'h0);
      probe(c0 + 19, K_TICK, 4'h1);
      probe(c0 + 29, K_TICK, 4'h1);

      // Clean press on channel 0.
      run_to(c0 + 3);
      pb[0] = 1'b1;
      p = pulse_at(cyc);
      want_pulse(p, 4'h1, 4'h0, 4'h0);
      want_long(p, 4'h1);
      probe(p - 1, K_LEVEL, 4'h0);
      probe(p, K_LEVEL, 4'h1);
      run_to(p + 100);

      // Channel 1 bounces every 15 clks for 120 clks, then holds high.
      e0 = cyc;
      pb[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         run_to(e0 + 15 * (i + 1));
         pb[1] = ~pb[1];
      end
      p = pulse_at(cyc);
      want_pulse(p, 4'h2, 4'h0, 4'h0);
      want_long(p, 4'h2);
      probe(p, K_LEVEL, 4'h3);
      run_to(p + 100);

      // Channels 2 and 3 pressed together, then released together.
      pb[3:2] = 2'b11;
      p = pulse_at(cyc);
      want_pulse(p, 4'hC, 4'h0, 4'h0);
      probe(p, K_LEVEL, 4'hF);
      run_to(p + 2);
      pb[3:2] = 2'b00;
      p2 = pulse_at(cyc);
      want_pulse(p2, 4'h0, 4'hC, 4'h0);
      probe(p2 - 1, K_LEVEL, 4'hF);
      probe(p2, K_LEVEL, 4'h3);
      run_to(p2 + 5);

      // Clean slate, then reset in the middle of a qualification on channel 0.
      rst = 1'b1;
      pb  = 4'h0;
      repeat (5) step();
      probe(cyc, K_LEVEL, 4'h0);
      probe(cyc, K_QUIET, 4'h0);
      rst = 1'b0;
      c0  = cyc;
      run_to(c0 + 2);
      pb[0] = 1'b1;
      k1 = pulse_at(cyc) - DIV * (STABLE_CNT - 1);
      run_to(k1 + 25);
      rst = 1'b1;
      step();
      rst = 1'b0;
      c0  = cyc;
      p = pulse_at(c0);
      probe(p - 1, K_LEVEL, 4'h0);
      want_pulse(p, 4'h1, 4'h0, 4'h0);
      want_long(p, 4'h1);
      probe(p, K_LEVEL, 4'h1);

      // Hold, release and press channel 0 again.
      run_to(p + 150);
      pb[0] = 1'b0;
      p2 = pulse_at(cyc);
      want_pulse(p2, 4'h0, 4'h1, 4'h0);
      probe(p2, K_LEVEL, 4'h0);
      run_to(p2 + 5);
      pb[0] = 1'b1;
      p3 = pulse_at(cyc);
      want_pulse(p3, 4'h1, 4'h0, 4'h0);
      want_long(p3, 4'h1);
      probe(p3 + 85, K_LEVEL, 4'h1);
      run_to(p3 + 90);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d, want completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
